// File: rtl/pit_support_pkg.sv
// Shared constants for the 8253 companion logic: control-port bit positions,
// the default divider increment, and the status-byte read helper.
package pit_support_pkg;

  localparam int CTRL_GATE2_BIT  = 0;
  localparam int CTRL_SPKR_BIT   = 1;
  localparam int STATUS_OUT2_BIT = 5;

  // round(2^24 * 2 * 1.193182 MHz / 50 MHz)
  localparam int unsigned PHASE_INC_50MHZ = 800731;

  // Port 61h read-back: control byte with bit 5 replaced by the live OUT2 level.
  function automatic logic [7:0] status_byte(input logic [7:0] ctrl, input logic out2);
    logic [7:0] r;
    r = ctrl;
    r[STATUS_OUT2_BIT] = out2;
    return r;
  endfunction

endpackage

// File: rtl/pit_phase_divider.sv
// Fractional phase-accumulator divider: each carry-out toggles a square wave,
// with the toggle landing one clock after the carry is generated.
module pit_phase_divider #(
  parameter int          ACC_WIDTH = 24,
  parameter int unsigned PHASE_INC = 800731
) (
  input  logic clock_i,
  input  logic reset_i,
  output logic square_o
);

  localparam logic [ACC_WIDTH:0] INC_EXT = (ACC_WIDTH + 1)'(PHASE_INC);

  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [ACC_WIDTH:0]   sum;
  logic                 carry_q, carry_d;
  logic                 square_q, square_d;

  // The residue is kept on wrap, so the long-run rate is exact.
  always_comb begin
    sum      = {1'b0, acc_q} + INC_EXT;
    acc_d    = sum[ACC_WIDTH-1:0];
    carry_d  = sum[ACC_WIDTH];
    square_d = square_q ^ carry_q;
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      acc_q    <= '0;
      carry_q  <= 1'b0;
      square_q <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      carry_q  <= carry_d;
      square_q <= square_d;
    end
  end

  assign square_o = square_q;

endmodule

// File: rtl/pit_timer_support.sv
// Glue around the 8253: PIT input clock, IRQ0 pulse from OUT0, and the port 61h
// speaker/gate register with a DC-silence mute on OUT2.
module pit_timer_support
  import pit_support_pkg::*;
#(
  parameter int          ACC_WIDTH      = 24,
  parameter int unsigned PHASE_INC      = PHASE_INC_50MHZ,
  parameter logic [19:0] SILENCE_CYCLES = 20'd1000000,
  parameter logic [7:0]  PORT_RESET     = 8'h00
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       chip_select_n,
  input  logic       read_enable_n,
  input  logic       write_enable_n,
  input  logic [7:0] data_bus_in,
  output logic [7:0] data_bus_out,
  output logic       pit_clock,
  input  logic       counter_0_out,
  input  logic       counter_2_out,
  output logic       counter_2_gate,
  output logic       interrupt_request_0,
  output logic       speaker_out
);

  pit_phase_divider #(
    .ACC_WIDTH (ACC_WIDTH),
    .PHASE_INC (PHASE_INC)
  ) u_divider (
    .clock_i  (clock),
    .reset_i  (reset),
    .square_o (pit_clock)
  );

  // Bus strobes: a write is active while chip_select_n and write_enable_n are
  // both low; data is captured every active cycle and committed on the first
  // inactive cycle. Reads are combinational while both read strobes are low.
  logic wr_active, rd_active;
  assign wr_active = !chip_select_n && !write_enable_n;
  assign rd_active = !chip_select_n && !read_enable_n;

  logic [7:0]  ctrl_q, ctrl_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic        wr_act_q;
  logic        c0_q, c0_qq, irq_q, irq_d;
  logic        c2_q, c2_qq;
  logic [19:0] sil_cnt_q, sil_cnt_d;
  logic        silent_q, silent_d;
  logic        spk_q, spk_d;

  always_comb begin
    wr_data_d = wr_active ? data_bus_in : wr_data_q;
    ctrl_d    = (wr_act_q && !wr_active) ? wr_data_q : ctrl_q;
    irq_d     = c0_q && !c0_qq;
    sil_cnt_d = sil_cnt_q;
    silent_d  = silent_q;
    if (c2_q != c2_qq) begin
      sil_cnt_d = '0;
      silent_d  = 1'b0;
    end else begin
      if (sil_cnt_q != SILENCE_CYCLES) sil_cnt_d = sil_cnt_q + 20'd1;
      if (sil_cnt_d == SILENCE_CYCLES) silent_d = 1'b1;
    end
    spk_d = ctrl_q[CTRL_SPKR_BIT] && c2_q && !silent_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ctrl_q    <= PORT_RESET;
      wr_data_q <= 8'h00;
      wr_act_q  <= 1'b0;
      c0_q      <= 1'b0;
      c0_qq     <= 1'b0;
      irq_q     <= 1'b0;
      c2_q      <= 1'b0;
      c2_qq     <= 1'b0;
      sil_cnt_q <= '0;
      silent_q  <= 1'b1;
      spk_q     <= 1'b0;
    end else begin
      ctrl_q    <= ctrl_d;
      wr_data_q <= wr_data_d;
      wr_act_q  <= wr_active;
      c0_q      <= counter_0_out;
      c0_qq     <= c0_q;
      irq_q     <= irq_d;
      c2_q      <= counter_2_out;
      c2_qq     <= c2_q;
      sil_cnt_q <= sil_cnt_d;
      silent_q  <= silent_d;
      spk_q     <= spk_d;
    end
  end

  assign data_bus_out        = rd_active ? status_byte(ctrl_q, c2_q) : 8'h00;
  assign counter_2_gate      = ctrl_q[CTRL_GATE2_BIT];
  assign interrupt_request_0 = irq_q;
  assign speaker_out         = spk_q;

endmodule

// File: tb/tb_pit_timer_support.sv
// Bench for pit_timer_support: a default instance plus a short-timeout instance
// sharing the same bus and counter inputs.
module tb_pit_timer_support;

  localparam longint INC = 800731;

  logic       clock = 1'b0;
  logic       reset;
  logic       chip_select_n, read_enable_n, write_enable_n;
  logic [7:0] data_bus_in;
  logic       counter_0_out, counter_2_out;
  logic [7:0] data_bus_out, data_bus_out_s;
  logic       pit_clock, pit_clock_s;
  logic       counter_2_gate, counter_2_gate_s;
  logic       interrupt_request_0, interrupt_request_0_s;
  logic       speaker_out, speaker_out_s;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];

  always #5 clock = ~clock;

  pit_timer_support dut (
    .clock(clock), .reset(reset), .chip_select_n(chip_select_n),
    .read_enable_n(read_enable_n), .write_enable_n(write_enable_n),
    .data_bus_in(data_bus_in), .data_bus_out(data_bus_out), .pit_clock(pit_clock),
    .counter_0_out(counter_0_out), .counter_2_out(counter_2_out),
    .counter_2_gate(counter_2_gate), .interrupt_request_0(interrupt_request_0),
    .speaker_out(speaker_out)
  );

  pit_timer_support #(.SILENCE_CYCLES(20'd16)) dut_s (
    .clock(clock), .reset(reset), .chip_select_n(chip_select_n),
    .read_enable_n(read_enable_n), .write_enable_n(write_enable_n),
    .data_bus_in(data_bus_in), .data_bus_out(data_bus_out_s), .pit_clock(pit_clock_s),
    .counter_0_out(counter_0_out), .counter_2_out(counter_2_out),
    .counter_2_gate(counter_2_gate_s), .interrupt_request_0(interrupt_request_0_s),
    .speaker_out(speaker_out_s)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_bus();
    chip_select_n  = 1'b1;
    read_enable_n  = 1'b1;
    write_enable_n = 1'b1;
    data_bus_in    = 8'h00;
  endtask

  task automatic write_port(input logic [7:0] v, input int hold);
    chip_select_n  = 1'b0;
    write_enable_n = 1'b0;
    data_bus_in    = v;
    repeat (hold) tick();
    chip_select_n  = 1'b1;
    write_enable_n = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_bus();
    counter_0_out = 1'b1;
    counter_2_out = 1'b1;
    chip_select_n = 1'b0;
    read_enable_n = 1'b0;
    repeat (3) tick();
    n_checks++; if (pit_clock !== 1'b0) begin n_fail++; $display("FAIL rst_pit_clock: got %b, expected 0", pit_clock); end
    n_checks++; if (counter_2_gate !== 1'b0) begin n_fail++; $display("FAIL rst_gate: got %b, expected 0", counter_2_gate); end
    n_checks++; if (interrupt_request_0 !== 1'b0) begin n_fail++; $display("FAIL rst_irq: got %b, expected 0", interrupt_request_0); end
    n_checks++; if (speaker_out !== 1'b0) begin n_fail++; $display("FAIL rst_speaker: got %b, expected 0", speaker_out); end
    n_checks++; if (data_bus_out !== 8'h00) begin n_fail++; $display("FAIL rst_data: got %h, expected 00", data_bus_out); end
    n_checks++; if ({pit_clock_s, counter_2_gate_s, interrupt_request_0_s, speaker_out_s, data_bus_out_s} !== 12'h000) begin
      n_fail++; $display("FAIL rst_short_inst: got %b%b%b%b %h, expected all zero",
                         pit_clock_s, counter_2_gate_s, interrupt_request_0_s, speaker_out_s, data_bus_out_s);
    end
    idle_bus();
    counter_0_out = 1'b0;
    counter_2_out = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_freq();
    int   rises = 0;
    logic prev;
    real  exp_r;
    int   exp_i;
    exp_r = 50000.0 * 1.193182 / 50.0;
    exp_i = int'(exp_r);
    prev  = pit_clock;
    repeat (50000) begin
      tick();
      if (pit_clock && !prev) rises++;
      prev = pit_clock;
    end
    n_checks++;
    if (rises < exp_i - 1 || rises > exp_i + 1) begin
      n_fail++; $display("FAIL pit_clock_rate: got %0d rises, expected %0d +/-1", rises, exp_i);
    end
  endtask

  task automatic test_write_commit();
    counter_2_out = 1'b0;
    repeat (2) tick();
    chip_select_n  = 1'b0;
    write_enable_n = 1'b0;
    data_bus_in    = 8'h03;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (counter_2_gate !== 1'b0) begin n_fail++; $display("FAIL gate_during_write%0d: got %b, expected 0", i, counter_2_gate); end
    end
    chip_select_n  = 1'b1;
    write_enable_n = 1'b1;
    #1;
    n_checks++; if (counter_2_gate !== 1'b0) begin n_fail++; $display("FAIL gate_before_commit: got %b, expected 0", counter_2_gate); end
    tick();
    n_checks++; if (counter_2_gate !== 1'b1) begin n_fail++; $display("FAIL gate_after_commit: got %b, expected 1", counter_2_gate); end
    chip_select_n = 1'b0;
    read_enable_n = 1'b0;
    #1;
    n_checks++; if (data_bus_out !== 8'h03) begin n_fail++; $display("FAIL read_out2_low: got %h, expected 03", data_bus_out); end
    counter_2_out = 1'b1;
    tick();
    n_checks++; if (data_bus_out !== 8'h23) begin n_fail++; $display("FAIL read_out2_high: got %h, expected 23", data_bus_out); end
    idle_bus();
    #1;
    n_checks++; if (data_bus_out !== 8'h00) begin n_fail++; $display("FAIL read_idle: got %h, expected 00", data_bus_out); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] vals [3];
    vals[0] = 8'hA5; vals[1] = 8'h5C; vals[2] = 8'h5C;
    counter_2_out = 1'b0;
    repeat (2) tick();
    chip_select_n  = 1'b0;
    write_enable_n = 1'b0;
    read_enable_n  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      data_bus_in = vals[i];
      tick();
      n_checks++; if (data_bus_out !== 8'h03) begin n_fail++; $display("FAIL b2b_no_early_commit%0d: got %h, expected 03", i, data_bus_out); end
    end
    write_enable_n = 1'b1;
    tick();
    n_checks++; if (data_bus_out !== 8'h5C) begin n_fail++; $display("FAIL b2b_final_value: got %h, expected 5c", data_bus_out); end
    n_checks++; if (counter_2_gate !== 1'b0) begin n_fail++; $display("FAIL b2b_gate: got %b, expected 0", counter_2_gate); end
    idle_bus();
  endtask

  task automatic test_irq();
    int pulses = 0;
    logic [7:0] e;
    counter_0_out = 1'b0;
    repeat (3) tick();
    counter_0_out = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      exp_q.push_back((k == 2) ? 8'h01 : 8'h00);
      tick();
      e = exp_q.pop_front();
      if (interrupt_request_0) pulses++;
      n_checks++; if ({7'd0, interrupt_request_0} !== e) begin n_fail++; $display("FAIL irq_cycle%0d: got %b, expected %0d", k, interrupt_request_0, e); end
    end
    n_checks++; if (pulses != 1) begin n_fail++; $display("FAIL irq_pulse_count: got %0d, expected 1", pulses); end
    counter_0_out = 1'b0;
  endtask

  task automatic test_speaker_follow();
    logic       v;
    logic [7:0] e;
    write_port(8'h03, 1);
    tick();
    counter_2_out = 1'b1;
    repeat (3) tick();
    exp_q.delete();
    // OUT2 toggles every 21 clocks; the speaker trails it by two clocks.
    for (int i = 0; i < 126; i++) begin
      v = ((i / 21) % 2) == 0;
      counter_2_out = v;
      exp_q.push_back({7'd0, v});
      tick();
      if (exp_q.size() == 2) begin
        e = exp_q.pop_front();
        n_checks++; if ({7'd0, speaker_out} !== e) begin n_fail++; $display("FAIL spk_follow%0d: got %b, expected %0d", i, speaker_out, e); end
      end
    end
    tick();
    e = exp_q.pop_front();
    n_checks++; if ({7'd0, speaker_out} !== e) begin n_fail++; $display("FAIL spk_follow_last: got %b, expected %0d", speaker_out, e); end
    counter_2_out = 1'b1;
    repeat (3) tick();
    n_checks++; if (speaker_out !== 1'b1) begin n_fail++; $display("FAIL spk_before_mute: got %b, expected 1", speaker_out); end
    write_port(8'h01, 1);
    tick();
    n_checks++; if (speaker_out !== 1'b1) begin n_fail++; $display("FAIL spk_at_commit: got %b, expected 1", speaker_out); end
    n_checks++; if (counter_2_gate !== 1'b1) begin n_fail++; $display("FAIL gate_after_mute: got %b, expected 1", counter_2_gate); end
    tick();
    n_checks++; if (speaker_out !== 1'b0) begin n_fail++; $display("FAIL spk_muted: got %b, expected 0", speaker_out); end
  endtask

  task automatic test_silence();
    logic [7:0] e;
    write_port(8'h03, 1);
    tick();
    counter_2_out = 1'b0;
    repeat (24) tick();
    counter_2_out = 1'b1;
    exp_q.delete();
    // Coming out of silence the unmute itself is registered, so the first
    // high lands one clock later than the steady two-clock follow.
    for (int k = 1; k <= 40; k++) begin
      exp_q.push_back((k >= 3 && k <= 18) ? 8'h01 : 8'h00);
      tick();
      e = exp_q.pop_front();
      n_checks++; if ({7'd0, speaker_out_s} !== e) begin n_fail++; $display("FAIL silence_cycle%0d: got %b, expected %0d", k, speaker_out_s, e); end
    end
    n_checks++; if (speaker_out !== 1'b1) begin n_fail++; $display("FAIL spk_default_no_timeout: got %b, expected 1", speaker_out); end
    counter_2_out = 1'b0;
    repeat (2) tick();
    counter_2_out = 1'b1;
    repeat (2) tick();
    n_checks++; if (speaker_out_s !== 1'b1) begin n_fail++; $display("FAIL silence_restore: got %b, expected 1", speaker_out_s); end
  endtask

  task automatic test_reset_mid_write();
    int     n = 0;
    longint exp_n;
    exp_n = ((64'd1 << 24) + INC - 1) / INC + 1;
    chip_select_n  = 1'b0;
    write_enable_n = 1'b0;
    read_enable_n  = 1'b0;
    data_bus_in    = 8'hFF;
    repeat (2) tick();
    #2 reset = 1'b1;
    #1;
    n_checks++; if (data_bus_out !== 8'h00) begin n_fail++; $display("FAIL midrst_data: got %h, expected 00", data_bus_out); end
    n_checks++; if ({pit_clock, counter_2_gate, speaker_out} !== 3'b000) begin
      n_fail++; $display("FAIL midrst_outputs: got %b%b%b, expected 000", pit_clock, counter_2_gate, speaker_out);
    end
    repeat (2) tick();
    idle_bus();
    tick();
    reset = 1'b0;
    while (pit_clock !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    n_checks++; if (n != exp_n) begin n_fail++; $display("FAIL first_toggle: got %0d clocks, expected %0d", n, exp_n); end
    chip_select_n = 1'b0;
    read_enable_n = 1'b0;
    #1;
    n_checks++; if (data_bus_out !== 8'h20) begin n_fail++; $display("FAIL no_commit_after_reset: got %h, expected 20", data_bus_out); end
    n_checks++; if (counter_2_gate !== 1'b0) begin n_fail++; $display("FAIL gate_after_reset: got %b, expected 0", counter_2_gate); end
    idle_bus();
    tick();
  endtask

  initial begin
    test_reset();
    test_freq();
    test_write_commit();
    test_back_to_back();
    test_irq();
    test_speaker_follow();
    test_silence();
    test_reset_mid_write();
    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule
